perf_counter_reader: RTL



---
 rtl/perf_counter_reader_pkg.sv | 22 ++
 rtl/perf_counter_reader.sv | 110 +++++++++++
 2 files changed

// File: rtl/perf_counter_reader_pkg.sv
// Shared widths and the read-sequencer state encoding for perf_counter_reader.
// Kept separate so CSR-side decoders can reuse the same word split.
package perf_counter_reader_pkg;

    localparam int CNT_W  = 64;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_SEND_LO = 2'd1,
        RD_SEND_HI = 2'd2
    } rd_state_t;

    function automatic logic [WORD_W-1:0] lo_word(input logic [CNT_W-1:0] v);
        return v[WORD_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] hi_word(input logic [CNT_W-1:0] v);
        return v[CNT_W-1:WORD_W];
    endfunction

endpackage

// File: rtl/perf_counter_reader.sv
// Atomic 64-bit snapshot of one event counter, streamed out as two 32-bit words
// (low first), with an optional one-cycle clear strobe back to the source counter.
module perf_counter_reader
    import perf_counter_reader_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int IDX_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_flat,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [IDX_W-1:0]         req_idx,
    input  logic                     req_clear,
    output logic [NUM_CNT-1:0]       clr_pulse,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WORD_W-1:0]        rsp_data,
    output logic                     rsp_last,
    output logic                     rsp_err
);

    // NUM_CNT always fits in IDX_W+1 bits because 2**IDX_W >= NUM_CNT.
    localparam logic [IDX_W:0] NUM_CNT_L = (IDX_W+1)'(NUM_CNT);

    rd_state_t           state;
    logic [CNT_W-1:0]    snap;
    logic [CNT_W-1:0]    cnt_arr [NUM_CNT];
    logic [CNT_W-1:0]    sel_val;
    logic [NUM_CNT-1:0]  clr_next;
    logic                idx_ok;
    logic                accept;

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_split
        assign cnt_arr[gi] = cnt_flat[gi*CNT_W +: CNT_W];
    end

    assign idx_ok = ({1'b0, req_idx} < NUM_CNT_L);
    assign accept = req_valid && req_ready;

    // Compare-based mux: an out-of-range index simply matches nothing and yields zero.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (req_idx == IDX_W'(k)) begin
                sel_val = cnt_arr[k];
            end
        end
    end

    always_comb begin
        clr_next = '0;
        if (req_clear && idx_ok) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                clr_next[k] = (req_idx == IDX_W'(k));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RD_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            clr_pulse <= '0;
            snap      <= '0;
        end else begin
            clr_pulse <= '0;
            case (state)
                RD_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        snap      <= idx_ok ? sel_val : '0;
                        rsp_data  <= idx_ok ? lo_word(sel_val) : '0;
                        rsp_valid <= 1'b1;
                        rsp_last  <= 1'b0;
                        rsp_err   <= !idx_ok;
                        req_ready <= 1'b0;
                        clr_pulse <= clr_next;
                        state     <= RD_SEND_LO;
                    end
                end
                RD_SEND_LO: begin
                    if (rsp_ready) begin
                        rsp_data <= hi_word(snap);
                        rsp_last <= 1'b1;
                        state    <= RD_SEND_HI;
                    end
                end
                RD_SEND_HI: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= RD_IDLE;
                    end
                end
                default: begin
                    state <= RD_IDLE;
                end
            endcase
        end
    end

endmodule
